// File: rtl/issue_scheduler_if.sv
// Decode-to-scheduler handshake plus issue strobes and writeback tag.
// The master side is the decode stage; the slave side is the scheduler.
interface issue_scheduler_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_eu_type;
  logic [5:0] in_rs1;
  logic [5:0] in_rs2;
  logic [5:0] in_rs3;
  logic [2:0] in_rs_used;
  logic [5:0] in_rd;
  logic       in_rd_we;
  logic [3:0] eu_en;
  logic       wb_valid;
  logic [5:0] wb_rd;

  modport master (
    output in_valid, in_eu_type, in_rs1, in_rs2, in_rs3, in_rs_used, in_rd, in_rd_we,
    input  in_ready, eu_en, wb_valid, wb_rd
  );

  modport slave (
    input  in_valid, in_eu_type, in_rs1, in_rs2, in_rs3, in_rs_used, in_rd, in_rd_we,
    output in_ready, eu_en, wb_valid, wb_rd
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue scheduler: stalls on RAW/WAW, divider occupancy and writeback
// port conflicts, fires one EU per cycle and tracks in-flight results to writeback.
module issue_scheduler #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16
) (
  input logic              clk,
  input logic              rst,
  issue_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_LAT);
  localparam logic [1:0] EU_MUL = 2'd1;
  localparam logic [1:0] EU_DIV = 2'd2;

  logic [63:0]               busy_q, busy_d;
  logic [DIV_LAT-1:0]        slot_valid_q, slot_valid_d;
  logic [DIV_LAT-1:0][5:0]   slot_tag_q, slot_tag_d;
  logic [CNT_W-1:0]          div_cnt_q, div_cnt_d;

  logic wr;
  logic raw;
  logic waw;
  logic div_stall;
  logic port_conflict;
  logic fire;
  int   lat;

  // Slot k of the tracker holds the result written back k cycles from now,
  // so a new write of latency L collides with whatever currently sits in slot L.
  always_comb begin
    case (bus.in_eu_type)
      EU_MUL:  lat = MUL_LAT;
      EU_DIV:  lat = DIV_LAT;
      default: lat = 1;
    endcase
    wr  = bus.in_rd_we && (bus.in_rd != 6'd0);
    raw = (bus.in_rs_used[0] && busy_q[bus.in_rs1]) ||
          (bus.in_rs_used[1] && busy_q[bus.in_rs2]) ||
          (bus.in_rs_used[2] && busy_q[bus.in_rs3]);
    waw       = wr && busy_q[bus.in_rd];
    div_stall = (bus.in_eu_type == EU_DIV) && (div_cnt_q != '0);
    port_conflict = 1'b0;
    for (int k = 1; k < DIV_LAT; k++) begin
      if (wr && (k == lat) && slot_valid_q[k]) port_conflict = 1'b1;
    end
    bus.in_ready = !(raw || waw || div_stall || port_conflict);
    fire         = bus.in_valid && bus.in_ready;
    bus.eu_en    = fire ? (4'b0001 << bus.in_eu_type) : 4'b0000;
  end

  assign bus.wb_valid = slot_valid_q[0];
  assign bus.wb_rd    = slot_tag_q[0];

  always_comb begin
    busy_d = busy_q;
    if (slot_valid_q[0]) busy_d[slot_tag_q[0]] = 1'b0;
    if (fire && wr) busy_d[bus.in_rd] = 1'b1;

    slot_valid_d = {1'b0, slot_valid_q[DIV_LAT-1:1]};
    slot_tag_d   = {6'd0, slot_tag_q[DIV_LAT-1:1]};
    if (fire && wr) begin
      for (int k = 0; k < DIV_LAT; k++) begin
        if (k == lat - 1) begin
          slot_valid_d[k] = 1'b1;
          slot_tag_d[k]   = bus.in_rd;
        end
      end
    end

    // Counter reaches zero exactly on the previous DIV's writeback cycle.
    div_cnt_d = div_cnt_q;
    if (fire && (bus.in_eu_type == EU_DIV)) div_cnt_d = CNT_W'(DIV_LAT - 1);
    else if (div_cnt_q != '0)               div_cnt_d = div_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      slot_valid_q <= '0;
      slot_tag_q   <= '0;
      div_cnt_q    <= '0;
    end else begin
      busy_q       <= busy_d;
      slot_valid_q <= slot_valid_d;
      slot_tag_q   <= slot_tag_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

In-order issue scheduler between the decode stage and the execution units (integer/FP ALU, multiplier, divider, branch/jump unit) of the RV64IMFD core. Accepts one decoded instruction per cycle, stalls it on RAW/WAW register hazards, divider occupancy and register-file write-port conflicts, then fires it to exactly one EU. Also tracks every in-flight result and emits the single register-file writeback strobe.

## Interface
Parameters:
- MUL_LAT, 3: multiplier latency in cycles, pipelined; legal range 2 to DIV_LAT-1.
- DIV_LAT, 16: divider latency in cycles, not pipelined; at least MUL_LAT+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  scheduler accepts the instruction this cycle (combinational).
- in_eu_type  in  2  target EU: 0 ALU, 1 MUL, 2 DIV, 3 BRANCH.
- in_rs1, in_rs2, in_rs3  in  6  source tags: bit 5 selects FP (1) or integer (0) file, bits 4:0 are the register number.
- in_rs_used  in  3  bit i set means source i+1 is read.
- in_rd  in  6  destination tag, same encoding as the source tags.
- in_rd_we  in  1  instruction writes in_rd.
- eu_en  out  4  one-hot issue strobe indexed by eu_type; all zero when nothing issues.
- wb_valid  out  1  register file writes wb_rd this cycle (registered).
- wb_rd  out  6  writeback tag (registered).

## Operation
- Issue condition: in_ready = no hazard. Fire = in_valid && in_ready. On fire, eu_en[in_eu_type] = 1 in the same cycle.
- Latency L by EU: ALU 1, BRANCH 1, MUL MUL_LAT, DIV DIV_LAT.
- Effective write: write = in_rd_we && in_rd != 0. Tag 0 (integer x0) never writes. FP tag 32 (f0) is a normal register.
- Scoreboard: 64 busy bits, one per tag.
  - Bit set on the edge ending a fire with write.
  - Bit cleared on the edge ending the cycle in which wb_valid is asserted for that tag.
  - Tag 0 is never busy.
- Hazards (any one stalls, giving in_ready=0):
  - RAW: a used source tag is busy.
  - WAW: write and in_rd is busy.
  - DIV busy: in_eu_type=2 and the divider is occupied. The divider is occupied from the cycle after a DIV fires through the cycle before its wb cycle.
  - Port conflict: write, and an already in-flight write occupies writeback cycle t+L.
- Writeback tracker: shift register of DIV_LAT slots, each holding {valid, tag}.
  - Slot 0 drives wb_valid/wb_rd.
  - Every edge, each slot shifts one place toward slot 0.
  - A fire with write at cycle t loads slot L-1, after the shift, with {1, in_rd}.
- Instructions without a write fire without touching the scoreboard or the tracker; divider occupancy still applies to DIV.
- There is no forwarding: a consumer of a result written back in cycle w issues at cycle w+1 at the earliest.
- in_ready does not depend on in_valid. Sources with in_rs_used=0 are ignored.

## Timing
- Reset (asynchronous, immediate):
  - Scoreboard all clear, tracker slots invalid, divider free.
  - wb_valid=0, wb_rd=0, eu_en=0, in_ready=1.
  - Reset mid-operation discards every in-flight result; no wb_valid is produced for them after release.
- Fire at cycle t with write gives wb_valid=1 and wb_rd=in_rd in exactly cycle t+L.
- Throughput: one fire per cycle when there is no hazard. MUL may fire back-to-back. A second DIV may fire at the earliest in cycle t+DIV_LAT, the previous DIV's wb cycle.
- Simultaneous clear and set of the same tag cannot occur because of the WAW stall. Clearing tag A while setting tag B on the same edge must both take effect.
- At most one wb_valid per cycle; this is guaranteed by the port-conflict stall.

## Test plan
- Reset: assert rst mid-stream with a DIV in flight -> wb_valid=0, in_ready=1, and no wb after release; an instruction with rs1 equal to that DIV's rd fires immediately.
- RAW: ALU rd=5 fires at cycle 0, then ALU rs1=5 presented at cycle 1 -> in_ready=0 in cycle 1, wb_valid with wb_rd=5 in cycle 1, consumer fires in cycle 2.
- Port conflict (MUL_LAT=3): MUL rd=7 at cycle 0, ALU rd=8 presented at cycle 2 -> ALU stalls in cycle 2 and fires in cycle 3; wb rd=7 in cycle 3 and rd=8 in cycle 4.
- DIV occupancy (DIV_LAT=16): DIV rd=9 at cycle 0, DIV rd=10 presented at cycle 1 -> stalled cycles 1-15, fires cycle 16; wb rd=9 at cycle 16, rd=10 at cycle 32.
- x0 handling: ALU rd=0 with in_rd_we=1, then ALU rs1=0 -> no stall, no wb_valid for either.
- FP/int separation: MUL rd=33 (f1) at cycle 0, ALU rs1=1 (x1) rd=2 at cycle 1 -> fires cycle 1; wb rd=2 at cycle 2 and rd=33 at cycle 3.
